// File: rtl/tqvp_bus_pkg.sv
// Shared types and helpers for the TinyQV peripheral bus initiator.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package tqvp_bus_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // True when the size is legal and the address is naturally aligned to it.
  function automatic logic addr_ok(input logic [5:0] addr, input logic [1:0] size);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~addr[0];
      SIZE_WORD: ok = (addr[1:0] == 2'b00);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Zero-extend the low bytes of data that belong to a transfer of this size.
  function automatic logic [31:0] size_mask(input logic [31:0] data, input logic [1:0] size);
    logic [31:0] r;
    r = 32'h0;
    case (size)
      SIZE_BYTE: r = {24'h0, data[7:0]};
      SIZE_HALF: r = {16'h0, data[15:0]};
      SIZE_WORD: r = data;
      default:   r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tqvp_bus_initiator.sv
// Host-side initiator for the TinyQV peripheral bus: one command in, bus strobes out, one response back.
// Latency: strobe 1 cycle after accept; response 2 cycles (write / immediate read), 1 cycle (error).
// Backpressure: cmd_ready only in IDLE; response held until rsp_ready, no new command meanwhile.
module tqvp_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 16  // 1..255 read-strobe cycles before timing out
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [5:0]  cmd_addr,
  input  logic [1:0]  cmd_size,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  per_address,
  output logic [31:0] per_data_in,
  output logic [1:0]  per_data_write_n,
  output logic [1:0]  per_data_read_n,
  input  logic [31:0] per_data_out,
  input  logic        per_data_ready,
  input  logic        per_user_interrupt,
  output logic        irq_level,
  output logic        irq_rise
);
  import tqvp_bus_pkg::*;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic [7:0] tmo_cnt;

  // Command/response FSM; every bus and response output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      cmd_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_rdata        <= 32'h0;
      rsp_err          <= 1'b0;
      per_address      <= 6'h0;
      per_data_in      <= 32'h0;
      per_data_write_n <= SIZE_NONE;
      per_data_read_n  <= SIZE_NONE;
      tmo_cnt          <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (!addr_ok(cmd_addr, cmd_size)) begin
              // Bad size or alignment never reaches the bus.
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (cmd_write) begin
              state            <= WRITE;
              per_address      <= cmd_addr;
              per_data_in      <= cmd_wdata;
              per_data_write_n <= cmd_size;
            end else begin
              state           <= READ;
              per_address     <= cmd_addr;
              per_data_read_n <= cmd_size;
              tmo_cnt         <= 8'h0;
            end
          end
        end
        WRITE: begin
          // Single-cycle write strobe; the peripheral's data_ready is not consulted.
          per_data_write_n <= SIZE_NONE;
          state            <= RESP;
          rsp_valid        <= 1'b1;
          rsp_err          <= 1'b0;
          rsp_rdata        <= 32'h0;
        end
        READ: begin
          if (per_data_ready) begin
            // The held read strobe still carries the transfer size.
            rsp_rdata       <= size_mask(per_data_out, per_data_read_n);
            rsp_err         <= 1'b0;
            rsp_valid       <= 1'b1;
            per_data_read_n <= SIZE_NONE;
            state           <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            rsp_rdata       <= 32'h0;
            rsp_err         <= 1'b1;
            rsp_valid       <= 1'b1;
            per_data_read_n <= SIZE_NONE;
            state           <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Interrupt sync flop plus rising-edge pulse aligned with irq_level going high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_level <= 1'b0;
      irq_rise  <= 1'b0;
    end else begin
      irq_level <= per_user_interrupt;
      irq_rise  <= per_user_interrupt & ~irq_level;
    end
  end

endmodule

// File: tb/tb_tqvp_bus_initiator.sv
// Directed bench for tqvp_bus_initiator with a response scoreboard.
// Latency: n/a.
// Backpressure: n/a.
module tb_tqvp_bus_initiator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [5:0]  cmd_addr;
  logic [1:0]  cmd_size;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [5:0]  per_address;
  logic [31:0] per_data_in;
  logic [1:0]  per_data_write_n;
  logic [1:0]  per_data_read_n;
  logic [31:0] per_data_out;
  logic        per_data_ready;
  logic        per_user_interrupt;
  logic        irq_level;
  logic        irq_rise;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t exp_r;

  int checks = 0;
  int errors = 0;

  // Simple peripheral: raises data_ready in the ready_after-th cycle of a read strobe.
  logic ready_en;
  int   ready_after;
  int   rd_seen = 0;

  assign per_data_ready = ready_en && (per_data_read_n != 2'b11) && (rd_seen == ready_after - 1);

  always @(posedge clk) rd_seen <= (per_data_read_n != 2'b11) ? rd_seen + 1 : 0;

  always #5 clk = ~clk;

  tqvp_bus_initiator #(.TIMEOUT_CYCLES(16)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cmd_valid          (cmd_valid),
    .cmd_ready          (cmd_ready),
    .cmd_write          (cmd_write),
    .cmd_addr           (cmd_addr),
    .cmd_size           (cmd_size),
    .cmd_wdata          (cmd_wdata),
    .rsp_valid          (rsp_valid),
    .rsp_ready          (rsp_ready),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .per_address        (per_address),
    .per_data_in        (per_data_in),
    .per_data_write_n   (per_data_write_n),
    .per_data_read_n    (per_data_read_n),
    .per_data_out       (per_data_out),
    .per_data_ready     (per_data_ready),
    .per_user_interrupt (per_user_interrupt),
    .irq_level          (irq_level),
    .irq_rise           (irq_rise)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every completed response is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {31'b0, rsp_valid}, 32'h0);
      end else begin
        exp_r = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, exp_r.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_r.err});
      end
    end
  end

  function automatic rsp_t mk(input logic [31:0] d, input logic e);
    rsp_t r;
    r.rdata = d;
    r.err   = e;
    return r;
  endfunction

  // Offer a command and return just after the accepting edge (cycle N+1 starts).
  task automatic send(input logic w, input logic [5:0] a, input logic [1:0] s, input logic [31:0] d);
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_size  = s;
    cmd_wdata = d;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("cmd_ready_wait", {31'b0, cmd_ready}, 32'h1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Watch n cycles from N+1: strobe counts, overlaps, last read size, first rsp_valid cycle.
  task automatic observe(input int n, output int wr, output int rd, output int both,
                         output logic [1:0] rdv, output int first);
    wr = 0; rd = 0; both = 0; rdv = 2'b11; first = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (per_data_write_n != 2'b11) wr++;
      if (per_data_read_n != 2'b11) begin
        rd++;
        rdv = per_data_read_n;
      end
      if (per_data_write_n != 2'b11 && per_data_read_n != 2'b11) both++;
      if (rsp_valid === 1'b1 && first < 0) first = i + 1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wr, rd, both, first;
    logic [1:0] rdv;

    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 6'h0; cmd_size = 2'b00; cmd_wdata = 32'h0;
    rsp_ready = 1'b1;
    per_data_out = 32'h12345678;
    per_user_interrupt = 1'b0;
    ready_en = 1'b0;
    ready_after = 1;

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
    check("rst_per_address", {26'b0, per_address}, 32'h0);
    check("rst_per_data_in", per_data_in, 32'h0);
    check("rst_write_n", {30'b0, per_data_write_n}, 32'h3);
    check("rst_read_n", {30'b0, per_data_read_n}, 32'h3);
    check("rst_irq_level", {31'b0, irq_level}, 32'h0);
    check("rst_irq_rise", {31'b0, irq_rise}, 32'h0);

    // Word write
    exp_q.push_back(mk(32'h0, 1'b0));
    send(1'b1, 6'h04, 2'b10, 32'hDEADBEEF);
    @(negedge clk);
    check("wr_write_n", {30'b0, per_data_write_n}, 32'h2);
    check("wr_address", {26'b0, per_address}, 32'h04);
    check("wr_data_in", per_data_in, 32'hDEADBEEF);
    check("wr_rsp_early", {31'b0, rsp_valid}, 32'h0);
    @(negedge clk);
    check("wr_strobe_end", {30'b0, per_data_write_n}, 32'h3);
    check("wr_rsp_n2", {31'b0, rsp_valid}, 32'h1);
    observe(3, wr, rd, both, rdv, first);
    check("wr_no_extra_strobe", wr, 0);
    check("wr_data_hold", per_data_in, 32'hDEADBEEF);

    // Byte read, ready in the third strobe cycle
    ready_en = 1'b1;
    ready_after = 3;
    exp_q.push_back(mk(32'h00000078, 1'b0));
    send(1'b0, 6'h01, 2'b00, 32'h0);
    observe(7, wr, rd, both, rdv, first);
    check("brd_strobe_cycles", rd, 3);
    check("brd_strobe_size", {30'b0, rdv}, 32'h0);
    check("brd_rsp_cycle", first, 4);
    check("brd_no_write", wr, 0);

    // Misaligned / illegal commands
    exp_q.push_back(mk(32'h0, 1'b1));
    send(1'b1, 6'h03, 2'b01, 32'hFFFF);
    observe(3, wr, rd, both, rdv, first);
    check("mis_half_strobes", wr + rd, 0);
    check("mis_half_rsp_cycle", first, 1);

    exp_q.push_back(mk(32'h0, 1'b1));
    send(1'b0, 6'h02, 2'b10, 32'h0);
    observe(3, wr, rd, both, rdv, first);
    check("mis_word_strobes", wr + rd, 0);
    check("mis_word_rsp_cycle", first, 1);

    exp_q.push_back(mk(32'h0, 1'b1));
    send(1'b0, 6'h00, 2'b11, 32'h0);
    observe(3, wr, rd, both, rdv, first);
    check("bad_size_strobes", wr + rd, 0);
    check("bad_size_rsp_cycle", first, 1);

    // Read timeout
    ready_en = 1'b0;
    exp_q.push_back(mk(32'h0, 1'b1));
    send(1'b0, 6'h08, 2'b10, 32'h0);
    observe(20, wr, rd, both, rdv, first);
    check("tmo_strobe_cycles", rd, 16);
    check("tmo_rsp_cycle", first, 17);
    check("tmo_strobe_size", {30'b0, rdv}, 32'h2);

    // Response backpressure on a half read
    ready_en = 1'b1;
    ready_after = 1;
    rsp_ready = 1'b0;
    exp_q.push_back(mk(32'h00005678, 1'b0));
    send(1'b0, 6'h02, 2'b01, 32'h0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
      check("bp_rsp_rdata", rsp_rdata, 32'h00005678);
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'h0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_after_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    check("bp_after_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    exp_q.push_back(mk(32'h0, 1'b0));
    send(1'b1, 6'h05, 2'b00, 32'h000000A5);
    observe(4, wr, rd, both, rdv, first);
    check("bp_next_write", wr, 1);
    check("bp_next_rsp_cycle", first, 2);

    // Reset while a read strobe is active
    ready_en = 1'b0;
    send(1'b0, 6'h10, 2'b10, 32'h0);
    @(negedge clk);
    check("rr_strobe_active", {30'b0, per_data_read_n}, 32'h2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rr_read_n", {30'b0, per_data_read_n}, 32'h3);
    check("rr_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rr_cmd_ready", {31'b0, cmd_ready}, 32'h1);
    check("rr_address", {26'b0, per_address}, 32'h0);
    observe(20, wr, rd, both, rdv, first);
    check("rr_no_rsp", first, -1);
    check("rr_no_strobe", rd + wr, 0);

    // Interrupt edge
    @(posedge clk);
    #1 per_user_interrupt = 1'b1;
    @(negedge clk);
    check("irq_level_pre", {31'b0, irq_level}, 32'h0);
    @(negedge clk);
    check("irq_level_rise", {31'b0, irq_level}, 32'h1);
    check("irq_rise_pulse", {31'b0, irq_rise}, 32'h1);
    @(negedge clk);
    check("irq_level_held", {31'b0, irq_level}, 32'h1);
    check("irq_rise_once", {31'b0, irq_rise}, 32'h0);

    check("sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
